// File: rtl/seg7_scan_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg -- shared types and constants for the two-digit 7-segment scanner.
//
// Contents:
//   state_e    : scan FSM states (DIG_HI = tens shown, DIG_LO = ones shown)
//   SEG_DASH   : pattern for non-decimal codes 10-15
//   SEG_BLANK  : all segments off (leading-zero blanking)
//   DIGIT_SEG  : patterns for 0-9, bit order {g,f,e,d,c,b,a}, 1 = lit
//   an_for     : digit-enable pattern for a given scan state
// ---------------------------------------------------------------------------
package seg7_pkg;

    typedef enum logic {
        DIG_HI = 1'b0,
        DIG_LO = 1'b1
    } state_e;

    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [6:0] DIGIT_SEG [10] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    // One-hot, active-high: an[1] = tens, an[0] = ones.
    function automatic logic [1:0] an_for(state_e s);
        return (s == DIG_HI) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// ---------------------------------------------------------------------------
// seg7_scan_ctrl_if -- BCD value handshake into the 7-segment scanner.
//
// Signals:
//   in_valid : source offers in_bcd
//   in_bcd   : [7:4] tens digit, [3:0] ones digit
//   in_ready : scanner accepts in_bcd this cycle (frame end only)
// Modports:
//   master : the BCD source
//   slave  : the scanner
// ---------------------------------------------------------------------------
interface seg7_scan_ctrl_if;
    logic       in_valid;
    logic [7:0] in_bcd;
    logic       in_ready;

    modport master (output in_valid, output in_bcd, input in_ready);
    modport slave  (input in_valid, input in_bcd, output in_ready);
endinterface

// File: rtl/seg7_scan_ctrl_bcd_to_seg7.sv
// ---------------------------------------------------------------------------
// bcd_to_seg7 -- combinational BCD digit to 7-segment pattern decoder.
//
// Ports:
//   bcd_i : 4-bit digit code
//   seg_o : segment pattern {g,f,e,d,c,b,a}, active-high; codes 10-15 give
//           a dash
// ---------------------------------------------------------------------------
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        if (bcd_i < 4'd10) begin
            seg_o = DIGIT_SEG[bcd_i];
        end
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg7_scan_ctrl -- two-digit multiplexed 7-segment display scanner.
//
// Alternates between the tens digit (DIG_HI) and the ones digit (DIG_LO),
// each shown for REFRESH_DIV clock cycles. A new BCD value is accepted only
// in the last cycle of DIG_LO, so every displayed frame is consistent.
//
// Parameters:
//   REFRESH_DIV : cycles each digit is shown per scan phase (>= 1)
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : seg7_scan_ctrl_if.slave (in_valid, in_bcd, in_ready)
//   seg_hi : tens-digit pattern (to downstream mux op1)
//   seg_lo : ones-digit pattern (to downstream mux op2)
//   sl     : mux select, 1 = tens, 0 = ones
//   an     : one-hot digit enable, an[1] = tens, an[0] = ones
// Configuration:
//   SEG7_LEAD_BLANK_EN : when defined, a tens digit of 0 is blanked
// ---------------------------------------------------------------------------
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    seg7_scan_ctrl_if.slave        bus,
    output logic [6:0]             seg_hi,
    output logic [6:0]             seg_lo,
    output logic                   sl,
    output logic [1:0]             an
);

    localparam int               CNT_W      = $clog2(REFRESH_DIV + 1);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(REFRESH_DIV - 1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       an_q;
    logic             sl_q;
    logic [3:0]       dig_q   [2];   // [1] = tens, [0] = ones
    logic [6:0]       dec_seg [2];

    logic term_cnt;
    logic started;
    logic accept;

    assign term_cnt = (cnt_q == '0);
    // an is 00 only between reset release and the first edge.
    assign started  = (an_q != 2'b00);

    // Frame end: last cycle of the ones digit.
    assign bus.in_ready = (state_q == DIG_LO) && term_cnt;
    assign accept       = bus.in_valid && bus.in_ready;

    // Scan FSM with registered select/enables. The first edge after reset
    // only switches the tens digit on and leaves the counter loaded, so the
    // first DIG_HI phase is visible for the full REFRESH_DIV cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= DIG_HI;
            cnt_q    <= CNT_RELOAD;
            an_q     <= 2'b00;
            sl_q     <= 1'b1;
            dig_q[0] <= 4'd0;
            dig_q[1] <= 4'd0;
        end else begin
            if (!started) begin
                an_q <= an_for(state_q);
                sl_q <= (state_q == DIG_HI);
            end else if (term_cnt) begin
                cnt_q <= CNT_RELOAD;
                case (state_q)
                    DIG_HI: begin
                        state_q <= DIG_LO;
                        an_q    <= an_for(DIG_LO);
                        sl_q    <= 1'b0;
                    end
                    DIG_LO: begin
                        state_q <= DIG_HI;
                        an_q    <= an_for(DIG_HI);
                        sl_q    <= 1'b1;
                    end
                endcase
            end else begin
                cnt_q <= cnt_q - CNT_W'(1);
            end

            // The capture edge is also the DIG_HI entry edge, so the new
            // patterns appear together with the start of the next frame.
            if (accept) begin
                dig_q[1] <= bus.in_bcd[7:4];
                dig_q[0] <= bus.in_bcd[3:0];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dec
            bcd_to_seg7 u_dec (
                .bcd_i (dig_q[gi]),
                .seg_o (dec_seg[gi])
            );
        end
    endgenerate

`ifdef SEG7_LEAD_BLANK_EN
    assign seg_hi = (dig_q[1] == 4'd0) ? SEG_BLANK : dec_seg[1];
`else
    assign seg_hi = dec_seg[1];
`endif
    assign seg_lo = dec_seg[0];

    assign sl = sl_q;
    assign an = an_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_ctrl -- scoreboard bench for seg7_scan_ctrl.
// Main DUT uses REFRESH_DIV = 4; a second instance uses REFRESH_DIV = 1.
// ---------------------------------------------------------------------------
module tb_seg7_scan_ctrl;

    localparam int DIV = 4;

    logic clk;
    logic rst_n;

    seg7_scan_ctrl_if bus  ();
    seg7_scan_ctrl_if bus1 ();

    logic [6:0] seg_hi, seg_lo, seg_hi1, seg_lo1;
    logic       sl, sl1;
    logic [1:0] an, an1;

    seg7_scan_ctrl #(.REFRESH_DIV(DIV)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .seg_hi (seg_hi),
        .seg_lo (seg_lo),
        .sl     (sl),
        .an     (an)
    );

    seg7_scan_ctrl #(.REFRESH_DIV(1)) dut1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus1),
        .seg_hi (seg_hi1),
        .seg_lo (seg_lo1),
        .sl     (sl1),
        .an     (an1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [13:0] exp_q [$];   // {seg_hi, seg_lo} expected after each accept
    logic [13:0] cur_exp;
    logic        hs_pending;
    int          edges;        // rising edges since reset release

    // ---------------- reference model ----------------
    function automatic logic [6:0] digit_pat(logic [3:0] d);
        case (d)
            4'd0: return 7'h3F;  4'd1: return 7'h06;  4'd2: return 7'h5B;
            4'd3: return 7'h4F;  4'd4: return 7'h66;  4'd5: return 7'h6D;
            4'd6: return 7'h7D;  4'd7: return 7'h07;  4'd8: return 7'h7F;
            4'd9: return 7'h6F;
            default: return 7'h40;
        endcase
    endfunction

    function automatic logic [13:0] ref_pair(logic [7:0] b);
        logic [6:0] hi;
        hi = digit_pat(b[7:4]);
`ifdef SEG7_LEAD_BLANK_EN
        if (b[7:4] == 4'd0) hi = 7'h00;
`endif
        return {hi, digit_pat(b[3:0])};
    endfunction

    // After n edges: edge 1 shows tens, then phases of d cycles alternate.
    function automatic logic [1:0] exp_an(int n, int d);
        if (n == 0) return 2'b00;
        return (((n - 1) / d) % 2 == 0) ? 2'b10 : 2'b01;
    endfunction

    function automatic logic exp_rdy(int n, int d);
        if (n == 0) return 1'b0;
        return (((n - 1) / d) % 2 == 1) && ((n - 1) % d == d - 1);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edges <= 0;
        else        edges <= edges + 1;
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            hs_pending = 1'b0;
            cur_exp    = ref_pair(8'h00);
            chk("rst_an", int'(an), 0);
            chk("rst_sl", int'(sl), 1);
            chk("rst_ready", int'(bus.in_ready), 0);
            chk("rst_seg_hi", int'(seg_hi), int'(cur_exp[13:7]));
            chk("rst_seg_lo", int'(seg_lo), int'(cur_exp[6:0]));
        end else begin
            if (hs_pending) begin
                hs_pending = 1'b0;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL accept_unexpected actual=accept required=none t=%0t", $time);
                end else begin
                    cur_exp = exp_q.pop_front();
                end
            end
            chk("seg_hi", int'(seg_hi), int'(cur_exp[13:7]));
            chk("seg_lo", int'(seg_lo), int'(cur_exp[6:0]));
            chk("an", int'(an), int'(exp_an(edges, DIV)));
            chk("sl", int'(sl), (exp_an(edges, DIV) == 2'b01) ? 0 : 1);
            chk("in_ready", int'(bus.in_ready), int'(exp_rdy(edges, DIV)));
            chk("div1_an", int'(an1), int'(exp_an(edges, 1)));
            chk("div1_sl", int'(sl1), (exp_an(edges, 1) == 2'b01) ? 0 : 1);
            chk("div1_ready", int'(bus1.in_ready), int'(exp_rdy(edges, 1)));
            hs_pending = bus.in_valid && bus.in_ready;
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [7:0] b);
        bit got;
        got = 1'b0;
        exp_q.push_back(ref_pair(b));
        bus.in_valid = 1'b1;
        bus.in_bcd   = b;
        for (int i = 0; i < 4 * DIV + 4 && !got; i++) begin
            @(negedge clk);
            if (bus.in_ready) got = 1'b1;
            @(posedge clk);
            #1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL handshake_timeout actual=no_ready required=ready bcd=%02h", b);
        end
        $display("TXN bcd=%02h accepted=%0d t=%0t", b, got, $time);
        bus.in_valid = 1'b0;
        bus.in_bcd   = 8'($urandom_range(0, 255));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [13:0] rst_exp;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_bcd    = 8'h00;
        bus1.in_valid = 1'b0;
        bus1.in_bcd   = 8'h00;
        cur_exp       = ref_pair(8'h00);
        hs_pending    = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;

        // Value offered from cycle 2 and held until the frame-end accept.
        repeat (2) @(posedge clk);
        #1;
        send(8'h47);

        // Mid-frame reset in frame cycle 6 with a handshake pending.
        repeat (5) @(posedge clk);
        #2;
        exp_q.push_back(ref_pair(8'h33));
        bus.in_valid = 1'b1;
        bus.in_bcd   = 8'h33;
        #1 rst_n = 1'b0;
        #1;
        rst_exp = ref_pair(8'h00);
        chk("async_rst_an", int'(an), 0);
        chk("async_rst_sl", int'(sl), 1);
        chk("async_rst_ready", int'(bus.in_ready), 0);
        chk("async_rst_seg_hi", int'(seg_hi), int'(rst_exp[13:7]));
        chk("async_rst_seg_lo", int'(seg_lo), int'(rst_exp[6:0]));
        exp_q.delete();
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;

        // Digits must read back as 0 for a full scan before the next load.
        repeat (2 * DIV + 1) @(posedge clk);
        #1;
        send(8'hA9);
        send(8'h05);
        send(8'h00);
        for (int k = 0; k < 12; k++) begin
            repeat ($urandom_range(0, 6)) @(posedge clk);
            #1;
            send(8'($urandom_range(0, 255)));
        end

        repeat (2 * DIV + 3) @(posedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_scan_ctrl.md
SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 SHALL provide parameter REFRESH_DIV, default 50000: clock cycles each digit is shown per scan phase; legal range >= 1.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port in_valid, input, 1 bit: a new BCD value is offered.
REQ-005 SHALL have port in_bcd, input, 8 bits: [7:4] tens digit, [3:0] ones digit.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts in_bcd this cycle.
REQ-007 SHALL have port seg_hi, output, 7 bits: tens-digit segment pattern, driven to the downstream 7-bit 2:1 mux op1.
REQ-008 SHALL have port seg_lo, output, 7 bits: ones-digit segment pattern, driven to the mux op2.
REQ-009 SHALL have port sl, output, 1 bit: mux select; 1 selects op1 (tens), 0 selects op2 (ones).
REQ-010 SHALL have port an, output, 2 bits: one-hot digit enable, active-high; an[1] is tens, an[0] is ones.

Function
REQ-011 Segment bit order SHALL be {g,f,e,d,c,b,a}, bit 6 = g, active-high (1 = lit).
REQ-012 Each digit SHALL decode 0-9 to standard patterns (0 = 7'h3F, 1 = 7'h06, 8 = 7'h7F, 9 = 7'h6F).
REQ-013 Codes 10-15 SHALL decode to a dash, 7'h40.
REQ-014 seg_hi and seg_lo SHALL be combinational decodes of two held digit registers, with no added latency.
REQ-015 FSM SHALL have two states: DIG_HI (sl=1, an=2'b10) and DIG_LO (sl=0, an=2'b01).
REQ-016 A down-counter SHALL run REFRESH_DIV cycles per state. At terminal count, DIG_HI SHALL move to DIG_LO, DIG_LO SHALL move to DIG_HI, and the counter SHALL reload.
REQ-017 sl and an SHALL be registered, changing on the same edge as the state.
REQ-018 in_ready SHALL be 1 only in the terminal-count cycle of DIG_LO (frame end); it SHALL be 0 otherwise.
REQ-019 When in_valid && in_ready, in_bcd SHALL be captured on that edge, and the new patterns SHALL appear on seg_hi/seg_lo in the next cycle, coincident with the DIG_HI entry.
REQ-020 in_valid without in_ready SHALL be ignored; the source holds in_bcd until the handshake completes.
REQ-021 When REFRESH_DIV = 1, states SHALL alternate every cycle, and in_ready SHALL pulse every second cycle.
REQ-022 Counter width SHALL be $clog2(REFRESH_DIV+1); the counter SHALL never underflow.

Reset
REQ-023 While rst_n = 0: state SHALL be DIG_HI, counter = REFRESH_DIV-1, digit registers = 0, sl = 1, an = 2'b00, in_ready = 0.
REQ-024 seg_hi and seg_lo SHALL be 7'h3F during reset, or 7'h00 and 7'h3F when SEG7_LEAD_BLANK_EN is defined.
REQ-025 After rst_n deasserts, the first edge SHALL set an = 2'b10.
REQ-026 Reset asserted mid-frame SHALL abort the frame immediately; any pending handshake SHALL be lost.

Configuration
REQ-027 Macro SEG7_LEAD_BLANK_EN defined: when the tens digit is 0, seg_hi SHALL be 7'h00 (blank); all other behaviour is unchanged.
REQ-028 Macro SEG7_LEAD_BLANK_EN undefined: a tens digit of 0 SHALL display as 7'h3F.

Structure
REQ-029 Package seg7_pkg SHALL hold the state enum (DIG_HI, DIG_LO), the segment constants (SEG_DASH = 7'h40, SEG_BLANK = 7'h00) and the 10-entry digit pattern table.
REQ-030 Sub-module bcd_to_seg7 (4-bit in, 7-bit out, combinational) SHALL be instantiated twice, once for tens and once for ones.

Verification (REFRESH_DIV = 4)
REQ-031 Reset, then release: an = 00 during reset; then an = 10, sl = 1 for 4 cycles; then an = 01, sl = 0 for 4 cycles; repeating.
REQ-032 Hold in_valid = 1, in_bcd = 8'h47 from cycle 2: accept only on the DIG_LO terminal cycle; next cycle seg_hi = 7'h66 and seg_lo = 7'h07.
REQ-033 in_bcd = 8'hA9: seg_hi = 7'h40 and seg_lo = 7'h6F.
REQ-034 in_bcd = 8'h05: with SEG7_LEAD_BLANK_EN, seg_hi = 7'h00; without it, seg_hi = 7'h3F. seg_lo = 7'h6D in both cases.
REQ-035 Assert rst_n = 0 at cycle 6 of a frame after loading 8'h47: outputs return to their reset values asynchronously, and digits read back as 0.
REQ-036 REFRESH_DIV = 1: sl toggles every cycle, and in_ready is high on every DIG_LO cycle.
